// File: rtl/alu_req_sequencer_if.sv
// Request/response bundle between two command sources, one response consumer
// and the ALU request sequencer.
interface alu_req_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic signed [WIDTH-1:0]   req0_a;
    logic signed [WIDTH-1:0]   req0_b;
    logic [3:0]                req0_fun;

    logic                      req1_valid;
    logic                      req1_ready;
    logic signed [WIDTH-1:0]   req1_a;
    logic signed [WIDTH-1:0]   req1_b;
    logic [3:0]                req1_fun;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_id;
    logic signed [2*WIDTH-1:0] rsp_data;
    logic                      rsp_carry;
    logic [3:0]                rsp_flags;
    logic                      rsp_err;

    // Requesters and response consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_flags, rsp_err
    );

    // Sequencer side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_req_sequencer.sv
// Round-robin sharing of one registered signed ALU between two requesters.
// Define ALU_SEQ_DIV0_CHECK_EN to answer divide-by-zero with an error instead of issuing it.
module alu_req_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_req_sequencer_if.slave        bus,
    output logic signed [WIDTH-1:0]   alu_a_o,
    output logic signed [WIDTH-1:0]   alu_b_o,
    output logic [3:0]                alu_fun_o,
    input  logic signed [2*WIDTH-1:0] alu_arith_out_i,
    input  logic                      alu_carry_out_i,
    input  logic signed [WIDTH-1:0]   alu_logic_out_i,
    input  logic signed [WIDTH-1:0]   alu_cmp_out_i,
    input  logic signed [WIDTH-1:0]   alu_shift_out_i,
    input  logic                      alu_arith_flag_i,
    input  logic                      alu_logic_flag_i,
    input  logic                      alu_cmp_flag_i,
    input  logic                      alu_shift_flag_i
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [3:0] FUN_NOP = 4'd8;
    localparam logic [3:0] FUN_DIV = 4'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      last_grant_q, last_grant_d;
    logic                      id_q, id_d;
    logic signed [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]                alu_fun_q, alu_fun_d;
    logic signed [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_carry_q, rsp_carry_d;
    logic [3:0]                rsp_flags_q, rsp_flags_d;
    logic                      rsp_err_q, rsp_err_d;

    logic                      pick1;
    logic                      accept;
    logic signed [WIDTH-1:0]   sel_a, sel_b;
    logic [3:0]                sel_fun;
    logic                      div0;

    function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // With both valid, the requester that did not win last time goes first.
    assign pick1   = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    assign accept  = (state_q == S_IDLE) & (bus.req0_valid | bus.req1_valid);
    assign sel_a   = pick1 ? bus.req1_a   : bus.req0_a;
    assign sel_b   = pick1 ? bus.req1_b   : bus.req0_b;
    assign sel_fun = pick1 ? bus.req1_fun : bus.req0_fun;

`ifdef ALU_SEQ_DIV0_CHECK_EN
    assign div0 = (sel_fun == FUN_DIV) && (sel_b == '0);
`else
    assign div0 = 1'b0;
`endif

    assign bus.req0_ready = (state_q == S_IDLE) & bus.req0_valid & ~pick1;
    assign bus.req1_ready = (state_q == S_IDLE) & pick1;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_fun_o      = alu_fun_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_fun_d    = alu_fun_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d         = pick1;
                    last_grant_d = pick1;
                    if (div0) begin
                        // Answered without touching the ALU; its inputs keep the last op.
                        rsp_data_d  = '0;
                        rsp_flags_d = 4'b1000;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_fun_d = sel_fun;
                        cnt_d     = CNT_W'(ALU_LAT - 1);
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_CAPT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CAPT: begin
                rsp_carry_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_flags_d = {alu_arith_flag_i, alu_logic_flag_i, alu_cmp_flag_i, alu_shift_flag_i};
                unique case (alu_fun_q[3:2])
                    2'b00: begin
                        rsp_data_d  = alu_arith_out_i;
                        rsp_carry_d = alu_carry_out_i;
                    end
                    2'b01:   rsp_data_d = sext(alu_logic_out_i);
                    2'b10:   rsp_data_d = sext(alu_cmp_out_i);
                    default: rsp_data_d = sext(alu_shift_out_i);
                endcase
                state_d = S_RESP;
            end
            default: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= FUN_NOP;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together at the edge.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_fun_q    <= alu_fun_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end
endmodule
